reg_file_sb: RTL
================

// Module: reg_file_sb
// PURPOSE
//  Parametrised 2-read/1-write CPU register file with an integrated scoreboard
//  (per-register busy bits) and optional write-to-read bypass. Sits between decode
//  (reads, reservations) and writeback (RuWr). Flags read-after-write hazards to
//  the pipeline control.
// PARAMETERS
//  DATA_W    4  register data width in bits
//  ADDR_W    2  register index width; depth NREG = 2**ADDR_W
//  ZERO_REG  1  1: register 0 reads as 0, ignores writes, never becomes busy
//  BYPASS    1  1: same-cycle write data is forwarded to ru1/ru2
// PORTS
//  clk       in   1       clock, all state updates on posedge
//  rst       in   1       synchronous, active-high reset
//  rs1,rs2   in   ADDR_W  read-port register selects
//  ru1,ru2   out  DATA_W  read data for rs1/rs2 (combinational)
//  rd        in   ADDR_W  writeback register index
//  RuWr      in   1       writeback enable
//  RuWrData  in   DATA_W  writeback data
//  rsv_en    in   1       reserve rsv_rd (an instruction issued that will write it)
//  rsv_rd    in   ADDR_W  register index to reserve
//  busy1     out  1       rs1 has a pending write not satisfied this cycle
//  busy2     out  1       rs2 has a pending write not satisfied this cycle
//  stall     out  1       busy1 | busy2 | rsv_conflict
//  rsv_ok    out  1       reservation accepted this cycle (rsv_en & ~rsv_conflict)
// BEHAVIOUR
//  Reset (rst=1 at posedge): every register <= 0, every busy bit <= 0. Reset wins over
//   RuWr/rsv_en in the same cycle. Outputs after reset: ru1=ru2=0, busy1=busy2=0,
//   stall=0, rsv_ok=rsv_en.
//  Read: ru = regs[rs] combinationally. ZERO_REG & rs==0 -> 0.
//   BYPASS & RuWr & rd==rs & ~(ZERO_REG & rd==0) -> ru = RuWrData in the same cycle.
//  Write: RuWr at posedge -> regs[rd] <= RuWrData. Visible next cycle (or same cycle
//   via bypass). Writes to reg 0 are dropped when ZERO_REG=1.
//  Scoreboard, per register i, evaluated at posedge (priority high->low):
//   1 rst                          -> busy[i] <= 0
//   2 rsv_ok & rsv_rd==i           -> busy[i] <= 1 (new reservation wins over same-cycle write)
//   3 RuWr & rd==i                 -> busy[i] <= 0
//   4 otherwise                    -> hold
//   ZERO_REG & i==0: busy[0] is a constant 0.
//  rsv_conflict = rsv_en & busy[rsv_rd] & ~(RuWr & rd==rsv_rd): WAW on an
//   outstanding write. The reservation is refused (rsv_ok=0) and stall=1.
//  busyN = busy[rsN] & ~(BYPASS & RuWr & rd==rsN). With BYPASS=0, a register that is
//   being written this cycle still reports busy. The data becomes valid next cycle.
//  RuWr to a non-busy register is legal: data is written, busy stays 0.
//  Simultaneous RuWr and rsv_en to the same rd: write performed, busy set (rule 2).
//  Reset during a pending write: the busy bit and data are cleared, and the write
//   is lost. The issuing pipeline flushes on rst.
//  Width rules: no arithmetic. All indices are full range 0..NREG-1, with no wrap.
// STRUCTURE
//  Shared package cpu_pkg: DATA_W/ADDR_W defaults, typedef reg_idx_t
//   (logic [ADDR_W-1:0]), typedef reg_data_t (logic [DATA_W-1:0]).
//  Sub-module reg_scoreboard: busy vector, rsv/clear logic, busy1/busy2/rsv_ok
//   outputs. It is instantiated once. The storage array, read muxes and bypass stay
//   in reg_file_sb.
// TESTING (defaults DATA_W=4, ADDR_W=2 unless stated)
//  1 rst=1 1 cycle, then rs1=1,rs2=3 -> ru1=ru2=0, busy1=busy2=stall=0.
//  2 RuWr=1,rd=2,RuWrData=4'hA; rs1=2 same cycle -> ru1=A (BYPASS=1); repeat with
//    BYPASS=0 -> ru1=0 that cycle, ru1=A next cycle.
//  3 RuWr=1,rd=0,data=4'hF (ZERO_REG=1) -> ru1(rs1=0)=0 forever; rsv_en,rsv_rd=0
//    -> rsv_ok=1, busy1(rs1=0)=0.
//  4 rsv_en,rsv_rd=1 -> next cycle rs1=1: busy1=1, stall=1; rsv_en,rsv_rd=1 again
//    -> rsv_ok=0; RuWr,rd=1,data=5 -> busy1=0 (BYPASS=1), ru1=5, following cycle busy1=0.
//  5 busy[3]=1; same cycle RuWr,rd=3 and rsv_en,rsv_rd=3 -> rsv_ok=1, regs[3]=data,
//    busy[3] stays 1.
//  6 busy[1]=busy[2]=1, regs nonzero; rst=1 with RuWr,rd=1 -> all regs 0, all busy 0;
//    randomized scoreboard check vs. reference model, DATA_W=32, ADDR_W=5.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared CPU register-file types and default widths.
// Pure declarations; no logic, no latency.
package cpu_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bundle of the register file: read ports, writeback, reservation, hazards.
// Wires only; ru/busy/stall/rsv_ok are combinational on the slave side, no backpressure path.
interface reg_file_sb_if import cpu_pkg::*; #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
);
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] ru1;
  logic [DATA_W-1:0] ru2;
  logic [ADDR_W-1:0] rd;
  logic              RuWr;
  logic [DATA_W-1:0] RuWrData;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_rd;
  logic              busy1;
  logic              busy2;
  logic              stall;
  logic              rsv_ok;

  modport master (
    output rs1, rs2, rd, RuWr, RuWrData, rsv_en, rsv_rd,
    input  ru1, ru2, busy1, busy2, stall, rsv_ok
  );

  modport slave (
    input  rs1, rs2, rd, RuWr, RuWrData, rsv_en, rsv_rd,
    output ru1, ru2, busy1, busy2, stall, rsv_ok
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy bits: set by accepted reservations, cleared by writeback.
// Hazard outputs are combinational; state updates one posedge later; a refused reservation is the backpressure.
module reg_scoreboard import cpu_pkg::*; #(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              wr_en,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_rd,
  output logic              busy1,
  output logic              busy2,
  output logic              rsv_ok,
  output logic              rsv_conflict
);
  localparam int NREG = 1 << ADDR_W;
  localparam bit ZR   = (ZERO_REG != 0);
  localparam bit BP   = (BYPASS != 0);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            wr_rs1;
  logic            wr_rs2;
  logic            wr_rsv;

  // Register 0 is hardwired idle when it is the zero register.
  always_comb begin
    busy = busy_q;
    if (ZR) busy[0] = 1'b0;
  end

  assign wr_rs1 = wr_en && (rd == rs1);
  assign wr_rs2 = wr_en && (rd == rs2);
  assign wr_rsv = wr_en && (rd == rsv_rd);

  // A writeback landing this cycle retires the outstanding write, so it is not a WAW.
  assign rsv_conflict = rsv_en && busy[rsv_rd] && !wr_rsv;
  assign rsv_ok       = rsv_en && !rsv_conflict;

  assign busy1 = busy[rs1] && !(BP && wr_rs1);
  assign busy2 = busy[rs2] && !(BP && wr_rs2);

  // Reservation is applied after the clear so a same-register reserve wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)  busy_nxt[rd]     = 1'b0;
    if (rsv_ok) busy_nxt[rsv_rd] = 1'b1;
    if (ZR)     busy_nxt[0]      = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end
endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with scoreboard and optional write-to-read bypass.
// Reads combinational, writes visible next cycle (same cycle with bypass); hazards reported via stall/rsv_ok.
module reg_file_sb import cpu_pkg::*; #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam bit ZR   = (ZERO_REG != 0);
  localparam bit BP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_ok;
  logic              rsv_conflict;

  assign wr_ok = bus.RuWr && !(ZR && (bus.rd == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.rd] <= bus.RuWrData;
    end
  end

  // wr_ok already excludes the zero register, so it doubles as the bypass qualifier.
  always_comb begin
    bus.ru1 = regs[bus.rs1];
    if (BP && wr_ok && (bus.rd == bus.rs1)) bus.ru1 = bus.RuWrData;
    if (ZR && (bus.rs1 == '0))              bus.ru1 = '0;
  end

  always_comb begin
    bus.ru2 = regs[bus.rs2];
    if (BP && wr_ok && (bus.rd == bus.rs2)) bus.ru2 = bus.RuWrData;
    if (ZR && (bus.rs2 == '0))              bus.ru2 = '0;
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rs1         (bus.rs1),
    .rs2         (bus.rs2),
    .rd          (bus.rd),
    .wr_en       (bus.RuWr),
    .rsv_en      (bus.rsv_en),
    .rsv_rd      (bus.rsv_rd),
    .busy1       (bus.busy1),
    .busy2       (bus.busy2),
    .rsv_ok      (bus.rsv_ok),
    .rsv_conflict(rsv_conflict)
  );

  assign bus.stall = bus.busy1 || bus.busy2 || rsv_conflict;
endmodule
